// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game sequencer: picks mole slots from an LFSR, times each mole,
// judges button presses, keeps a saturating two-digit BCD score and a miss
// count, and signals the end of the game. Every output is a register.
module whack_game_ctrl #(
    parameter int unsigned MOLE_TIMEOUT    = 100000000,
    parameter int unsigned FEEDBACK_CYCLES = 50000000,
    parameter int unsigned MAX_MISSES      = 3,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] btn,
    output logic [2:0] mole_position,
    output logic       guess_correct,
    output logic       guess_wrong,
    output logic       game_over,
    output logic [3:0] digit_1,
    output logic [3:0] digit_2,
    output logic [2:0] misses
);

    // A zero seed would lock the LFSR, so it is swapped for a known-good value.
    localparam logic [15:0] SEED_EFF     = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [31:0] TIMEOUT_LAST = 32'(MOLE_TIMEOUT - 32'd1);
    localparam logic [31:0] FB_LAST      = 32'(FEEDBACK_CYCLES - 32'd1);
    localparam logic [2:0]  MISS_LIMIT   = 3'(MAX_MISSES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SPAWN    = 3'd1,
        ST_WAIT     = 3'd2,
        ST_FEEDBACK = 3'd3,
        ST_OVER     = 3'd4
    } state_t;

    // Increment a two-digit BCD score, holding at 99.
    function automatic logic [7:0] bcd_inc_sat(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] res;
        if ((tens == 4'd9) && (ones == 4'd9)) begin
            res = {tens, ones};
        end else if (ones == 4'd9) begin
            res = {tens + 4'd1, 4'd0};
        end else begin
            res = {tens, ones + 4'd1};
        end
        return res;
    endfunction

    // Fold the low LFSR bits onto 0..4 and step past the current slot so a
    // mole never reappears in the same place twice in a row.
    function automatic logic [2:0] pick_slot(input logic [2:0] rnd, input logic [2:0] cur);
        logic [2:0] p;
        if (rnd >= 3'd5) begin
            p = rnd - 3'd5;
        end else begin
            p = rnd;
        end
        if (p == cur) begin
            p = (p == 3'd4) ? 3'd0 : (p + 3'd1);
        end else begin
            p = p;
        end
        return p;
    endfunction

    state_t      state_r, state_s;
    logic [15:0] lfsr_r;
    logic        lfsr_fb_s;
    logic [31:0] timer_r, timer_s;
    logic [2:0]  pos_r, pos_s;
    logic [2:0]  slot_s;
    logic [4:0]  target_s;
    logic        gc_r, gc_s, gw_r, gw_s, go_r, go_s;
    logic [3:0]  tens_r, tens_s, ones_r, ones_s;
    logic [2:0]  misses_r, misses_s, miss_inc_s;
    logic [7:0]  score_inc_s;

    assign lfsr_fb_s   = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
    assign slot_s      = pick_slot(lfsr_r[2:0], pos_r);
    assign target_s    = 5'b00001 << pos_r;
    assign miss_inc_s  = misses_r + 3'd1;
    assign score_inc_s = bcd_inc_sat(tens_r, ones_r);

    // Next-state and next-output logic for the game sequencer.
    always_comb begin
        state_s  = state_r;
        timer_s  = timer_r;
        pos_s    = pos_r;
        tens_s   = tens_r;
        ones_s   = ones_r;
        misses_s = misses_r;
        gc_s     = 1'b0;
        gw_s     = 1'b0;
        go_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    tens_s   = 4'd0;
                    ones_s   = 4'd0;
                    misses_s = 3'd0;
                    state_s  = ST_SPAWN;
                end else begin
                    state_s  = state_r;
                end
            end
            ST_SPAWN: begin
                pos_s   = slot_s;
                timer_s = 32'd0;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (btn == target_s) begin
                    gc_s    = 1'b1;
                    tens_s  = score_inc_s[7:4];
                    ones_s  = score_inc_s[3:0];
                    timer_s = 32'd0;
                    state_s = ST_FEEDBACK;
                end else if ((btn != 5'd0) || (timer_r == TIMEOUT_LAST)) begin
                    gw_s     = 1'b1;
                    misses_s = miss_inc_s;
                    timer_s  = 32'd0;
                    if (miss_inc_s == MISS_LIMIT) begin
                        go_s    = 1'b1;
                        state_s = ST_OVER;
                    end else begin
                        state_s = ST_FEEDBACK;
                    end
                end else begin
                    timer_s = timer_r + 32'd1;
                end
            end
            ST_FEEDBACK: begin
                if (timer_r == FB_LAST) begin
                    timer_s = 32'd0;
                    state_s = ST_SPAWN;
                end else begin
                    timer_s = timer_r + 32'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = 32'd0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            lfsr_r   <= SEED_EFF;
            timer_r  <= 32'd0;
            pos_r    <= 3'd0;
            gc_r     <= 1'b0;
            gw_r     <= 1'b0;
            go_r     <= 1'b0;
            tens_r   <= 4'd0;
            ones_r   <= 4'd0;
            misses_r <= 3'd0;
        end else begin
            state_r  <= state_s;
            lfsr_r   <= {lfsr_r[14:0], lfsr_fb_s};
            timer_r  <= timer_s;
            pos_r    <= pos_s;
            gc_r     <= gc_s;
            gw_r     <= gw_s;
            go_r     <= go_s;
            tens_r   <= tens_s;
            ones_r   <= ones_s;
            misses_r <= misses_s;
        end
    end

    assign mole_position = pos_r;
    assign guess_correct = gc_r;
    assign guess_wrong   = gw_r;
    assign game_over     = go_r;
    assign digit_1       = tens_r;
    assign digit_2       = ones_r;
    assign misses        = misses_r;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Self-checking bench for whack_game_ctrl: a vector table for the timeout
// game, directed sequences for hits, scoring and reset, then random play
// checked every cycle against a behavioural game model.
module tb_whack_game_ctrl;

    localparam int          TO   = 16;
    localparam int          FB   = 4;
    localparam int          MAXM = 3;
    localparam logic [15:0] SEED = 16'h0001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [4:0] btn = 5'd0;
    logic [2:0] mole_position;
    logic       guess_correct, guess_wrong, game_over;
    logic [3:0] digit_1, digit_2;
    logic [2:0] misses;

    whack_game_ctrl #(
        .MOLE_TIMEOUT(TO), .FEEDBACK_CYCLES(FB), .MAX_MISSES(MAXM), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .btn(btn),
        .mole_position(mole_position), .guess_correct(guess_correct),
        .guess_wrong(guess_wrong), .game_over(game_over),
        .digit_1(digit_1), .digit_2(digit_2), .misses(misses)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: score as an integer, mole age / pause counters.
    logic [15:0] m_lfsr = SEED;
    int m_pos = 0, m_score = 0, m_misses = 0, m_age = -1, m_pause = 0;
    bit m_spawn = 1'b0, m_gc = 1'b0, m_gw = 1'b0, m_go = 1'b0;

    function automatic logic [4:0] oh(input int p);
        logic [4:0] one;
        one = 5'b00001;
        return one << p;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input logic [4:0] b);
        int p;
        m_gc = 1'b0; m_gw = 1'b0; m_go = 1'b0;
        if (!r) begin
            m_lfsr = SEED; m_pos = 0; m_score = 0; m_misses = 0;
            m_age = -1; m_pause = 0; m_spawn = 1'b0;
            return;
        end
        p = int'(m_lfsr[2:0]) % 5;
        if (p == m_pos) p = (p + 1) % 5;
        if (m_spawn) begin
            m_pos = p; m_spawn = 1'b0; m_age = 0;
        end else if (m_age >= 0) begin
            if (b == oh(m_pos)) begin
                m_gc = 1'b1;
                if (m_score < 99) m_score++;
                m_age = -1; m_pause = FB;
            end else if (b != 5'd0 || m_age == TO - 1) begin
                m_gw = 1'b1; m_misses++; m_age = -1;
                if (m_misses == MAXM) m_go = 1'b1;
                else m_pause = FB;
            end else begin
                m_age++;
            end
        end else if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) m_spawn = 1'b1;
        end else if (s) begin
            m_score = 0; m_misses = 0; m_spawn = 1'b1;
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    // One clock: drive on the falling edge, model the rising edge, sample 1 ns later.
    task automatic tick(input bit r, input bit s, input logic [4:0] b);
        @(negedge clk);
        rst = r; start = s; btn = b;
        @(posedge clk);
        model_edge(r, s, b);
        #1;
        check("mole_position", mole_position, m_pos);
        check("guess_correct", guess_correct, m_gc);
        check("guess_wrong", guess_wrong, m_gw);
        check("game_over", game_over, m_go);
        check("digit_1", digit_1, m_score / 10);
        check("digit_2", digit_2, m_score % 10);
        check("misses", misses, m_misses);
    endtask

    task automatic wait_mole();
        for (int i = 0; i < 64; i++) begin
            if (m_age >= 0) break;
            tick(1'b1, 1'b0, 5'd0);
        end
        n_cmp++;
        if (m_age < 0) begin
            n_bad++;
            $display("FAIL wait_mole: no mole within 64 cycles");
        end
    endtask

    typedef struct {
        bit         r;
        bit         s;
        logic [4:0] b;
        int         reps;
        bit         gc, gw, go;
        int         d1, d2, mis;
        int         pos;   // -1: slot not checked by this row
    } vec_t;

    vec_t tbl[16];

    initial begin
        int prev;
        logic [4:0] b;
        // Reset, idle, then a game lost entirely by timeouts.
        tbl[0]  = '{1'b0, 1'b0, 5'd0,  2,  1'b0, 1'b0, 1'b0, 0, 0, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 5'd0,  20, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0};
        tbl[2]  = '{1'b1, 1'b1, 5'd0,  1,  1'b0, 1'b0, 1'b0, 0, 0, 0, 0};
        tbl[3]  = '{1'b1, 1'b0, 5'd0,  1,  1'b0, 1'b0, 1'b0, 0, 0, 0, -1};
        tbl[4]  = '{1'b1, 1'b0, 5'd0,  15, 1'b0, 1'b0, 1'b0, 0, 0, 0, -1};
        tbl[5]  = '{1'b1, 1'b0, 5'd0,  1,  1'b0, 1'b1, 1'b0, 0, 0, 1, -1};
        tbl[6]  = '{1'b1, 1'b0, 5'd0,  4,  1'b0, 1'b0, 1'b0, 0, 0, 1, -1};
        tbl[7]  = '{1'b1, 1'b0, 5'd0,  1,  1'b0, 1'b0, 1'b0, 0, 0, 1, -1};
        tbl[8]  = '{1'b1, 1'b0, 5'd0,  15, 1'b0, 1'b0, 1'b0, 0, 0, 1, -1};
        tbl[9]  = '{1'b1, 1'b0, 5'd0,  1,  1'b0, 1'b1, 1'b0, 0, 0, 2, -1};
        tbl[10] = '{1'b1, 1'b0, 5'd0,  4,  1'b0, 1'b0, 1'b0, 0, 0, 2, -1};
        tbl[11] = '{1'b1, 1'b0, 5'd0,  1,  1'b0, 1'b0, 1'b0, 0, 0, 2, -1};
        tbl[12] = '{1'b1, 1'b0, 5'd0,  15, 1'b0, 1'b0, 1'b0, 0, 0, 2, -1};
        tbl[13] = '{1'b1, 1'b0, 5'd0,  1,  1'b0, 1'b1, 1'b1, 0, 0, 3, -1};
        tbl[14] = '{1'b1, 1'b0, 5'h1F, 3,  1'b0, 1'b0, 1'b0, 0, 0, 3, -1};
        tbl[15] = '{1'b1, 1'b0, 5'h01, 3,  1'b0, 1'b0, 1'b0, 0, 0, 3, -1};

        for (int v = 0; v < 16; v++) begin
            for (int k = 0; k < tbl[v].reps; k++) begin
                tick(tbl[v].r, tbl[v].s, tbl[v].b);
                check($sformatf("tbl%0d_gc", v), guess_correct, tbl[v].gc);
                check($sformatf("tbl%0d_gw", v), guess_wrong, tbl[v].gw);
                check($sformatf("tbl%0d_go", v), game_over, tbl[v].go);
                check($sformatf("tbl%0d_d1", v), digit_1, tbl[v].d1);
                check($sformatf("tbl%0d_d2", v), digit_2, tbl[v].d2);
                check($sformatf("tbl%0d_mis", v), misses, tbl[v].mis);
                if (tbl[v].pos >= 0) check($sformatf("tbl%0d_pos", v), mole_position, tbl[v].pos);
            end
        end

        // Restart from OVER clears score and misses.
        tick(1'b1, 1'b1, 5'd0);
        check("restart_misses", misses, 0);
        check("restart_d2", digit_2, 0);
        tick(1'b1, 1'b0, 5'd0);
        // Hit on the third WAIT cycle.
        tick(1'b1, 1'b0, 5'd0);
        tick(1'b1, 1'b0, 5'd0);
        prev = m_pos;
        tick(1'b1, 1'b0, oh(m_pos));
        check("hit_gc", guess_correct, 1);
        check("hit_d2", digit_2, 1);
        tick(1'b1, 1'b0, 5'd0);
        check("hit_gc_one_cycle", guess_correct, 0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 5'd0);
        check("new_slot_differs", int'(mole_position != 3'(prev)), 1);
        // start during WAIT is ignored.
        tick(1'b1, 1'b1, 5'd0);
        check("start_in_wait_d2", digit_2, 1);

        // Run the score up to 99, checking the first decade carry.
        for (int i = 0; i < 120 && m_score < 99; i++) begin
            wait_mole();
            tick(1'b1, 1'b0, oh(m_pos));
            check("run_gc", guess_correct, 1);
            if (m_score == 10) begin
                check("carry_d1", digit_1, 1);
                check("carry_d2", digit_2, 0);
            end
        end
        wait_mole();
        tick(1'b1, 1'b0, oh(m_pos));
        check("sat_gc", guess_correct, 1);
        check("sat_d1", digit_1, 9);
        check("sat_d2", digit_2, 9);

        // Correct press on the last timer cycle beats the timeout.
        wait_mole();
        for (int i = 0; i < TO - 1; i++) tick(1'b1, 1'b0, 5'd0);
        tick(1'b1, 1'b0, oh(m_pos));
        check("late_hit_gc", guess_correct, 1);
        check("late_hit_gw", guess_wrong, 0);

        // Multi-bit press including the correct bit is a miss.
        wait_mole();
        tick(1'b1, 1'b0, oh(m_pos) | oh((m_pos + 2) % 5));
        check("multi_gw", guess_wrong, 1);
        check("multi_gc", guess_correct, 0);

        // Reset mid-WAIT, even alongside a correct press, yields reset values.
        wait_mole();
        tick(1'b0, 1'b0, oh(m_pos));
        check("rst_gc", guess_correct, 0);
        check("rst_gw", guess_wrong, 0);
        check("rst_pos", mole_position, 0);
        check("rst_d1", digit_1, 0);
        check("rst_misses", misses, 0);

        // Random play against the model.
        for (int i = 0; i < 3000; i++) begin
            int k;
            k = int'($urandom_range(0, 9));
            if (k < 6) b = 5'd0;
            else if (k < 8) b = oh(m_pos);
            else b = 5'($urandom);
            tick($urandom_range(0, 499) != 0, $urandom_range(0, 29) == 0, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
